// File: rtl/forward_pkg.sv
// Shared definitions for the forward-stage arbiter: stream widths, FSM encoding
// and the default release holdoff.
package forward_pkg;

    localparam int AXIS_DATA_W       = 64;
    localparam int AXIS_KEEP_W       = 8;
    localparam int IDLE_HOLD_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2,
        ST_DRAIN = 2'd3
    } fwd_state_e;

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin search: first set request at or after ptr, wrapping
// modulo N.
module rr_arbiter_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic             hit,
    output logic [PTR_W-1:0] idx
);

    logic [N-1:0]     rot;
    logic [PTR_W-1:0] widx [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            logic [PTR_W:0] sum;
            assign sum      = {1'b0, ptr} + (PTR_W+1)'(gi);
            assign widx[gi] = (sum >= (PTR_W+1)'(N)) ? PTR_W'(sum - (PTR_W+1)'(N))
                                                     : sum[PTR_W-1:0];
            assign rot[gi]  = req[widx[gi]];
        end
    endgenerate

    // Scan from the far end so the smallest offset from ptr wins.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                hit = 1'b1;
                idx = widx[i];
            end
        end
    end

endmodule

// File: rtl/forward_arbiter.sv
// Round-robin arbiter granting one forward-buffer stage at a time and muxing its
// AXI-Stream onto a single egress until the stage has drained and gone idle.
module forward_arbiter
    import forward_pkg::*;
#(
    parameter int N_PORTS   = 4,
    parameter int IDLE_HOLD = IDLE_HOLD_DEFAULT,
    parameter int PTR_W     = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [N_PORTS-1:0]             i_forward_req,
    output logic [N_PORTS-1:0]             o_forward_resp,
    input  logic [N_PORTS-1:0]             i_forward_finish,
    input  logic [N_PORTS-1:0]             s_axis_tvalid,
    input  logic [N_PORTS*AXIS_DATA_W-1:0] s_axis_tdata,
    input  logic [N_PORTS-1:0]             s_axis_tlast,
    input  logic [N_PORTS*AXIS_KEEP_W-1:0] s_axis_tkeep,
    output logic [N_PORTS-1:0]             s_axis_tready,
    output logic                           m_axis_tvalid,
    output logic [AXIS_DATA_W-1:0]         m_axis_tdata,
    output logic                           m_axis_tlast,
    output logic [AXIS_KEEP_W-1:0]         m_axis_tkeep,
    output logic                           m_axis_tuser,
    input  logic                           m_axis_tready,
    output logic                           o_busy,
    output logic [PTR_W-1:0]               o_grant_idx
);

    localparam int              CNT_W = 4;
    localparam logic [CNT_W-1:0] HOLD = CNT_W'(IDLE_HOLD);

    fwd_state_e         state_reg;
    logic [N_PORTS-1:0] resp_reg;
    logic [PTR_W-1:0]   rr_ptr_reg;
    logic [PTR_W-1:0]   grant_idx_reg;
    logic               pkt_seen_reg;
    logic               in_pkt_reg;
    logic [CNT_W-1:0]   idle_cnt_reg;

    logic               pick_hit;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic               egress_on;
    logic               beat;
    logic               sel_valid;
    logic               sel_last;
    logic               sel_finish;
    logic               sel_req;

    logic [AXIS_DATA_W-1:0] data_arr [N_PORTS];
    logic [AXIS_KEEP_W-1:0] keep_arr [N_PORTS];

    rr_arbiter_pick #(
        .N     (N_PORTS),
        .PTR_W (PTR_W)
    ) u_pick (
        .req (i_forward_req),
        .ptr (rr_ptr_reg),
        .hit (pick_hit),
        .idx (pick_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_port
            assign data_arr[gi]      = s_axis_tdata[gi*AXIS_DATA_W +: AXIS_DATA_W];
            assign keep_arr[gi]      = s_axis_tkeep[gi*AXIS_KEEP_W +: AXIS_KEEP_W];
            assign s_axis_tready[gi] = egress_on && (grant_idx_reg == PTR_W'(gi)) && m_axis_tready;
        end
    endgenerate

    assign sel_valid  = s_axis_tvalid[grant_idx_reg];
    assign sel_last   = s_axis_tlast[grant_idx_reg];
    assign sel_finish = i_forward_finish[grant_idx_reg];
    assign sel_req    = i_forward_req[grant_idx_reg];
    assign next_ptr   = (grant_idx_reg == PTR_W'(N_PORTS - 1)) ? '0 : grant_idx_reg + 1'b1;

    assign egress_on     = (state_reg == ST_XFER) || (state_reg == ST_DRAIN);
    assign m_axis_tvalid = egress_on && sel_valid;
    assign m_axis_tdata  = egress_on ? data_arr[grant_idx_reg] : '0;
    assign m_axis_tlast  = egress_on && sel_last;
    assign m_axis_tkeep  = egress_on ? keep_arr[grant_idx_reg] : '0;
    assign m_axis_tuser  = 1'b0;
    assign beat          = m_axis_tvalid && m_axis_tready;

    assign o_forward_resp = resp_reg;
    assign o_grant_idx    = grant_idx_reg;
    assign o_busy         = (state_reg != ST_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= ST_IDLE;
            resp_reg      <= '0;
            rr_ptr_reg    <= '0;
            grant_idx_reg <= '0;
            pkt_seen_reg  <= 1'b0;
            in_pkt_reg    <= 1'b0;
            idle_cnt_reg  <= '0;
        end else begin
            // Packet framing is tracked whenever the egress is open.
            if (egress_on && beat) begin
                if (sel_last) begin
                    in_pkt_reg   <= 1'b0;
                    pkt_seen_reg <= 1'b1;
                end else begin
                    in_pkt_reg <= 1'b1;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (pick_hit) begin
                        grant_idx_reg      <= pick_idx;
                        resp_reg           <= '0;
                        resp_reg[pick_idx] <= 1'b1;
                        state_reg          <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (sel_req) begin
                        resp_reg     <= '0;
                        pkt_seen_reg <= 1'b0;
                        in_pkt_reg   <= 1'b0;
                        idle_cnt_reg <= '0;
                        state_reg    <= ST_XFER;
                    end else begin
                        resp_reg  <= '0;
                        state_reg <= ST_IDLE;
                    end
                end
                ST_XFER: begin
                    // finish can rise before the last packet's data shows up, so
                    // release only after a run of truly idle cycles.
                    if (sel_valid || in_pkt_reg || !sel_finish) begin
                        idle_cnt_reg <= '0;
                    end else if (idle_cnt_reg != HOLD) begin
                        idle_cnt_reg <= idle_cnt_reg + 1'b1;
                    end
                    if (pkt_seen_reg && (idle_cnt_reg == HOLD)) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (sel_valid) begin
                        idle_cnt_reg <= '0;
                        state_reg    <= ST_XFER;
                    end else begin
                        rr_ptr_reg <= next_ptr;
                        state_reg  <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_forward_arbiter.sv
// Directed bench for forward_arbiter: single port, backpressure, round-robin
// order, finish race, withdrawn request and mid-packet reset.
module tb_forward_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   resp;
    logic [N-1:0]   finish;
    logic [N-1:0]   s_tvalid;
    logic [N*64-1:0] s_tdata;
    logic [N-1:0]   s_tlast;
    logic [N*8-1:0] s_tkeep;
    logic [N-1:0]   s_tready;
    logic           m_tvalid;
    logic [63:0]    m_tdata;
    logic           m_tlast;
    logic [7:0]     m_tkeep;
    logic           m_tuser;
    logic           m_tready;
    logic           busy;
    logic [1:0]     gidx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    forward_arbiter #(
        .N_PORTS   (N),
        .IDLE_HOLD (4),
        .PTR_W     (2)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_forward_req    (req),
        .o_forward_resp   (resp),
        .i_forward_finish (finish),
        .s_axis_tvalid    (s_tvalid),
        .s_axis_tdata     (s_tdata),
        .s_axis_tlast     (s_tlast),
        .s_axis_tkeep     (s_tkeep),
        .s_axis_tready    (s_tready),
        .m_axis_tvalid    (m_tvalid),
        .m_axis_tdata     (m_tdata),
        .m_axis_tlast     (m_tlast),
        .m_axis_tkeep     (m_tkeep),
        .m_axis_tuser     (m_tuser),
        .m_axis_tready    (m_tready),
        .o_busy           (busy),
        .o_grant_idx      (gidx)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request port p, expect the registered resp, then complete the handshake.
    task automatic open_session(input int p);
        req[p]    = 1'b1;
        finish[p] = 1'b0;
        tick();
        chk("resp_on", resp, 64'(1) << p);
        chk("grant_idx", gidx, 64'(p));
        chk("busy_grant", busy, 1);
        tick();
        req[p] = 1'b0;
        chk("resp_off", resp, 0);
        chk("busy_xfer", busy, 1);
    endtask

    // Offer beats 0..n_send-1 of an n-beat packet; rdy bit c is m_tready in cycle c.
    task automatic send_pkt(input int p, input int n, input int n_send, input logic [63:0] base,
                            input logic [7:0] last_keep, input logic [15:0] rdy);
        int b = 0;
        int c = 0;
        while (b < n_send && c < 16) begin
            s_tvalid[p]         = 1'b1;
            s_tdata[p*64 +: 64] = base + 64'(b);
            s_tlast[p]          = (b == n - 1);
            s_tkeep[p*8 +: 8]   = (b == n - 1) ? last_keep : 8'hFF;
            m_tready            = rdy[c];
            #1;
            chk("m_valid", m_tvalid, 1);
            chk("m_data", m_tdata, base + 64'(b));
            chk("m_last", m_tlast, 64'(b == n - 1));
            chk("m_keep", m_tkeep, (b == n - 1) ? 64'(last_keep) : 64'hFF);
            chk("s_ready", s_tready, 64'(rdy[c]) << p);
            @(posedge clk);
            #1;
            if (rdy[c]) b++;
            c++;
        end
        if (b < n_send) chk("pkt_timeout", 64'(b), 64'(n_send));
        s_tvalid[p] = 1'b0;
        s_tlast[p]  = 1'b0;
        m_tready    = 1'b1;
    endtask

    // Raise finish right after the last beat: 4 idle counts, DRAIN, then IDLE.
    task automatic release_session(input int p);
        finish[p] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 5) chk("busy_hold", busy, 1);
        end
        chk("busy_release", busy, 0);
        chk("grant_keep", gidx, 64'(p));
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        finish   = '1;
        s_tvalid = '1;
        s_tdata  = {N{64'hDEAD_BEEF_0000_0001}};
        s_tlast  = '1;
        s_tkeep  = '1;
        m_tready = 1'b1;
        repeat (2) tick();
        chk("rst_resp", resp, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gidx", gidx, 0);
        chk("rst_mvalid", m_tvalid, 0);
        chk("rst_mdata", m_tdata, 0);
        chk("rst_mlast", m_tlast, 0);
        chk("rst_mkeep", m_tkeep, 0);
        chk("rst_sready", s_tready, 0);
        chk("rst_tuser", m_tuser, 0);
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        s_tkeep  = '0;
        rst_n    = 1'b1;
        tick();

        // Single port 0, 5 beats, partial keep on the last beat; rr_ptr -> 1.
        open_session(0);
        send_pkt(0, 5, 5, 64'h1000, 8'h0F, 16'hFFFF);
        release_session(0);

        // Ports 0 and 1 request: rr_ptr=1 picks 1; 6-beat packet under backpressure.
        req[0] = 1'b1;
        open_session(1);
        req[0] = 1'b0;
        send_pkt(1, 6, 6, 64'h2000, 8'hFF, 16'h9999);
        release_session(1);

        // All ports request with rr_ptr=2: order 2,3,0,1.
        req    = '1;
        finish = '0;
        open_session(2);
        send_pkt(2, 2, 2, 64'h3200, 8'h03, 16'hFFFF);
        release_session(2);
        open_session(3);
        send_pkt(3, 1, 1, 64'h3300, 8'h01, 16'hFFFF);
        release_session(3);
        open_session(0);
        send_pkt(0, 3, 3, 64'h3000, 8'h07, 16'hFFFF);
        release_session(0);
        open_session(1);
        send_pkt(1, 2, 2, 64'h3100, 8'h3F, 16'hFFFF);
        release_session(1);

        // Finish race on port 2: finish rises 3 cycles before the final packet.
        open_session(2);
        send_pkt(2, 2, 2, 64'h4000, 8'hFF, 16'hFFFF);
        finish[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("race_busy", busy, 1);
        end
        send_pkt(2, 2, 2, 64'h4100, 8'h1F, 16'hFFFF);
        release_session(2);

        // Withdrawn request on port 3 (rr_ptr=3), with data offered meanwhile.
        s_tvalid[3]       = 1'b1;
        s_tdata[3*64 +: 64] = 64'h5555;
        req[3]            = 1'b1;
        tick();
        req[3] = 1'b0;
        chk("wd_resp_on", resp, 64'h8);
        chk("wd_busy", busy, 1);
        chk("wd_mvalid_g", m_tvalid, 0);
        chk("wd_sready_g", s_tready, 0);
        tick();
        chk("wd_resp_off", resp, 0);
        chk("wd_busy_off", busy, 0);
        chk("wd_mvalid", m_tvalid, 0);
        s_tvalid[3] = 1'b0;

        // rr_ptr still 3: ports 0 and 3 requesting picks 3; then 0 follows.
        req[0]    = 1'b1;
        finish[0] = 1'b0;
        open_session(3);
        send_pkt(3, 1, 1, 64'h6000, 8'hFF, 16'hFFFF);
        release_session(3);

        // Port 0 session, reset asserted while beat 3 of 8 is on the egress.
        open_session(0);
        send_pkt(0, 8, 2, 64'h7000, 8'hFF, 16'hFFFF);
        s_tvalid[0]         = 1'b1;
        s_tdata[0*64 +: 64] = 64'h7002;
        s_tkeep[0*8 +: 8]   = 8'hFF;
        #1;
        chk("pre_rst_mvalid", m_tvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_mvalid", m_tvalid, 0);
        chk("midrst_resp", resp, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_mdata", m_tdata, 0);
        chk("midrst_sready", s_tready, 0);
        s_tvalid = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        req      = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_gidx", gidx, 0);
        req = 4'b1010;
        tick();
        chk("post_rst_pick", resp, 64'h2);
        chk("post_rst_gidx1", gidx, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
